// File: rtl/jtag_dbg_pkg.sv
// jtag_dbg_pkg: shared constants for the JTAG debug controller.
//   - TAP state encodings seen on jtag_state
//   - debug instruction opcodes
//   - bit positions of the status word
//   - memory-port FSM state type
package jtag_dbg_pkg;

    // TAP states that cause an action; every other encoding is ignored
    localparam logic [3:0] TAP_SHIFT_DR   = 4'h2;
    localparam logic [3:0] TAP_CAPTURE_DR = 4'h4;
    localparam logic [3:0] TAP_UPDATE_DR  = 4'h5;
    localparam logic [3:0] TAP_SHIFT_IR   = 4'hA;
    localparam logic [3:0] TAP_UPDATE_IR  = 4'hD;

    // Instruction opcodes; unlisted values are no-ops
    localparam logic [3:0] OP_READ_MEM  = 4'd1;
    localparam logic [3:0] OP_WRITE_MEM = 4'd2;
    localparam logic [3:0] OP_SET_ADDR  = 4'd3;
    localparam logic [3:0] OP_SET_BP    = 4'd4;
    localparam logic [3:0] OP_HALT      = 4'd5;
    localparam logic [3:0] OP_RESUME    = 4'd6;
    localparam logic [3:0] OP_STEP      = 4'd7;
    localparam logic [3:0] OP_STATUS    = 4'd8;
    localparam logic [3:0] OP_CLR_BP    = 4'd9;

    // Status word layout: {zeros, bp_ptr, bp_hit, err, busy, halt}
    localparam int ST_HALT     = 0;
    localparam int ST_BUSY     = 1;
    localparam int ST_ERR      = 2;
    localparam int ST_BP_HIT   = 3;
    localparam int ST_BP_PTR   = 4;
    localparam int ST_BP_PTR_W = 4;   // wide enough for up to 16 slots

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_e;

endpackage

// File: rtl/jtag_dbg_ctrl_if.sv
// jtag_dbg_ctrl_if: memory access port of the debug controller.
//   mem_addr/mem_wdata/mem_we/mem_req : request, driven by the controller
//   mem_rdata/mem_ack                 : response, driven by the memory side
// modport master = controller, modport slave = memory.
interface jtag_dbg_ctrl_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] mem_addr;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_addr, mem_req, mem_we, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_req, mem_we, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/jtag_dbg_ctrl_bp_unit.sv
// dbg_bp_unit: hardware breakpoint slots.
//   clk, reset     : clock, async active-high reset
//   set_bp         : write bp_value into slot bp_ptr, enable it, advance bp_ptr
//   clr_bp         : disable all slots, bp_ptr = 0
//   resume         : record core_pc as resume_pc and mask matches on it
//   core_pc(_valid): program counter under observation
//   match          : combinational hit on an enabled, unmasked slot
//   bp_ptr         : next slot to be written (zero-extended to 4 bits)
module dbg_bp_unit #(
    parameter int DATA_W = 32,
    parameter int NUM_BP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_bp,
    input  logic              clr_bp,
    input  logic              resume,
    input  logic [DATA_W-1:0] bp_value,
    input  logic [DATA_W-1:0] core_pc,
    input  logic              core_pc_valid,
    output logic              match,
    output logic [3:0]        bp_ptr
);
    localparam int PTR_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

    logic [DATA_W-1:0] slot [NUM_BP];
    logic [NUM_BP-1:0] slot_en;
    logic [NUM_BP-1:0] slot_hit;
    logic [PTR_W-1:0]  ptr;
    logic              mask;
    logic [DATA_W-1:0] resume_pc;
    logic              masked_pc;

    always_comb begin
        slot_hit = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            slot_hit[i] = slot_en[i] && (slot[i] == core_pc);
        end
    end

    // The mask only suppresses the pc we resumed from; any other pc may hit
    // immediately, and the first different valid pc lifts the mask.
    assign masked_pc = mask && (core_pc == resume_pc);
    assign match     = core_pc_valid && (|slot_hit) && !resume && !masked_pc;
    assign bp_ptr    = 4'(ptr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BP; i++) begin
                slot[i] <= '0;
            end
            slot_en   <= '0;
            ptr       <= '0;
            mask      <= 1'b0;
            resume_pc <= '0;
        end else begin
            if (clr_bp) begin
                slot_en <= '0;
                ptr     <= '0;
            end else if (set_bp) begin
                slot[ptr]    <= bp_value;
                slot_en[ptr] <= 1'b1;
                ptr          <= (ptr == PTR_W'(NUM_BP - 1)) ? '0 : ptr + PTR_W'(1);
            end

            if (resume) begin
                mask      <= 1'b1;
                resume_pc <= core_pc;
            end else if (mask && core_pc_valid && (core_pc != resume_pc)) begin
                mask <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/jtag_dbg_ctrl.sv
// jtag_dbg_ctrl: JTAG-driven debug controller.
//   clk, reset           : system clock, async active-high reset
//   jtag_state, tdi, tdo : TAP state (sampled every clk), serial in/out
//   mem (master modport) : single-outstanding memory access port
//   core_pc(_valid)      : core program counter for breakpoint compare
//   halt, step           : core run control; step is a one-cycle pulse
//
// Memory port FSM:
//   state    | meaning
//   MEM_IDLE | no request outstanding, mem_req = 0
//   MEM_BUSY | request presented, held stable until mem_ack
module jtag_dbg_ctrl
    import jtag_dbg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IR_W   = 4,
    parameter int NUM_BP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        jtag_state,
    input  logic              tdi,
    output logic              tdo,
    jtag_dbg_ctrl_if.master   mem,
    input  logic [DATA_W-1:0] core_pc,
    input  logic              core_pc_valid,
    output logic              halt,
    output logic              step
);
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] status_word;
    logic [IR_W-1:0]   ir_shift;
    logic [IR_W-1:0]   instruction;
    logic              we_q;
    logic              err;
    logic              bp_hit;

    mem_state_e mem_state, mem_state_nxt;

    logic st_shift_dr, st_capture_dr, st_update_dr, st_shift_ir, st_update_ir;
    logic op_read, op_write, op_set_addr, op_set_bp, op_halt;
    logic op_resume, op_step, op_status, op_clr_bp;
    logic mem_req, busy, ack_now, upd_access, accept, drop;
    logic cmd_halt, cmd_resume, cmd_step;
    logic bp_match;
    logic [3:0] bp_ptr;

    assign st_shift_dr   = (jtag_state == TAP_SHIFT_DR);
    assign st_capture_dr = (jtag_state == TAP_CAPTURE_DR);
    assign st_update_dr  = (jtag_state == TAP_UPDATE_DR);
    assign st_shift_ir   = (jtag_state == TAP_SHIFT_IR);
    assign st_update_ir  = (jtag_state == TAP_UPDATE_IR);

    assign op_read     = (instruction == IR_W'(OP_READ_MEM));
    assign op_write    = (instruction == IR_W'(OP_WRITE_MEM));
    assign op_set_addr = (instruction == IR_W'(OP_SET_ADDR));
    assign op_set_bp   = (instruction == IR_W'(OP_SET_BP));
    assign op_halt     = (instruction == IR_W'(OP_HALT));
    assign op_resume   = (instruction == IR_W'(OP_RESUME));
    assign op_step     = (instruction == IR_W'(OP_STEP));
    assign op_status   = (instruction == IR_W'(OP_STATUS));
    assign op_clr_bp   = (instruction == IR_W'(OP_CLR_BP));

    assign mem_req = (mem_state == MEM_BUSY);
    assign ack_now = mem_req && mem.mem_ack;
    assign busy    = mem_req && !mem.mem_ack;

    // An access landing in the ack cycle is not busy and so is accepted,
    // giving back-to-back requests with no idle cycle.
    assign upd_access = st_update_dr && (op_read || op_write);
    assign accept     = upd_access && !busy;
    assign drop       = upd_access && busy;

    assign cmd_halt   = st_update_dr && op_halt;
    assign cmd_resume = st_update_dr && op_resume;
    assign cmd_step   = st_update_dr && op_step;

    always_comb begin
        status_word                            = '0;
        status_word[ST_HALT]                   = halt;
        status_word[ST_BUSY]                   = busy;
        status_word[ST_ERR]                    = err;
        status_word[ST_BP_HIT]                 = bp_hit;
        status_word[ST_BP_PTR +: ST_BP_PTR_W]  = bp_ptr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_state <= MEM_IDLE;
        end else begin
            mem_state <= mem_state_nxt;
        end
    end

    always_comb begin
        mem_state_nxt = mem_state;
        case (mem_state)
            MEM_IDLE: if (accept) mem_state_nxt = MEM_BUSY;
            MEM_BUSY: if (ack_now) mem_state_nxt = accept ? MEM_BUSY : MEM_IDLE;
            default:  mem_state_nxt = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tdo         <= 1'b0;
            shift_reg   <= '0;
            ir_shift    <= '0;
            instruction <= '0;
            rdata_reg   <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (st_shift_dr) begin
                shift_reg <= {tdi, shift_reg[DATA_W-1:1]};
                tdo       <= shift_reg[0];
            end else if (st_capture_dr) begin
                if (op_read) begin
                    shift_reg <= rdata_reg;
                end else if (op_status) begin
                    shift_reg <= status_word;
                end
            end

            if (st_shift_ir) begin
                ir_shift <= {tdi, ir_shift[IR_W-1:1]};
            end
            if (st_update_ir) begin
                instruction <= ir_shift;
            end

            if (ack_now) begin
                addr_q <= addr_q + DATA_W'(DATA_W / 8);
                if (!we_q) begin
                    rdata_reg <= mem.mem_rdata;
                end
            end

            // Address reload is ignored while a request is outstanding so the
            // bus stays stable; in the ack cycle it overrides the increment.
            if (st_update_dr && op_set_addr && !busy) begin
                addr_q <= shift_reg;
            end

            if (accept) begin
                we_q <= op_write;
                if (op_write) begin
                    wdata_q <= shift_reg;
                end
            end

            if (drop) begin
                err <= 1'b1;
            end else if (st_update_dr && op_status) begin
                err <= 1'b0;
            end
        end
    end

    // HALT has priority over RESUME; a breakpoint coincident with RESUME is
    // already suppressed inside the breakpoint unit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt   <= 1'b0;
            bp_hit <= 1'b0;
            step   <= 1'b0;
        end else begin
            step <= cmd_step && halt;
            if (cmd_halt) begin
                halt <= 1'b1;
            end else if (cmd_resume) begin
                halt   <= 1'b0;
                bp_hit <= 1'b0;
            end else if (bp_match) begin
                halt   <= 1'b1;
                bp_hit <= 1'b1;
            end
        end
    end

    dbg_bp_unit #(
        .DATA_W (DATA_W),
        .NUM_BP (NUM_BP)
    ) u_bp_unit (
        .clk           (clk),
        .reset         (reset),
        .set_bp        (st_update_dr && op_set_bp),
        .clr_bp        (st_update_dr && op_clr_bp),
        .resume        (cmd_resume),
        .bp_value      (shift_reg),
        .core_pc       (core_pc),
        .core_pc_valid (core_pc_valid),
        .match         (bp_match),
        .bp_ptr        (bp_ptr)
    );

    assign mem.mem_req   = mem_req;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_jtag_dbg_ctrl.sv
// tb_jtag_dbg_ctrl: directed and randomized bench for jtag_dbg_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_jtag_dbg_ctrl;
    import jtag_dbg_pkg::*;

    localparam int DATA_W = 32;
    localparam int NUM_BP = 4;
    localparam logic [3:0] TAP_IDLE = 4'hF;

    logic              clk;
    logic              reset;
    logic [3:0]        jtag_state;
    logic              tdi;
    logic              tdo;
    logic [DATA_W-1:0] core_pc;
    logic              core_pc_valid;
    logic              halt;
    logic              step;

    int n_assert = 0;
    int n_fail   = 0;

    jtag_dbg_ctrl_if #(.DATA_W(DATA_W)) mem_bus ();

    jtag_dbg_ctrl #(
        .DATA_W (DATA_W),
        .IR_W   (4),
        .NUM_BP (NUM_BP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .jtag_state    (jtag_state),
        .tdi           (tdi),
        .tdo           (tdo),
        .mem           (mem_bus),
        .core_pc       (core_pc),
        .core_pc_valid (core_pc_valid),
        .halt          (halt),
        .step          (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [3:0] op);
        for (int i = 0; i < 4; i++) begin
            jtag_state = TAP_SHIFT_IR;
            tdi        = op[i];
            tick();
        end
        jtag_state = TAP_UPDATE_IR;
        tick();
        jtag_state = TAP_IDLE;
    endtask

    task automatic dr_scan(input logic [31:0] din, output logic [31:0] dout);
        dout       = '0;
        jtag_state = TAP_CAPTURE_DR;
        tick();
        for (int i = 0; i < DATA_W; i++) begin
            jtag_state = TAP_SHIFT_DR;
            tdi        = din[i];
            tick();
            dout[i]    = tdo;
        end
        jtag_state = TAP_IDLE;
    endtask

    task automatic dr_update();
        jtag_state = TAP_UPDATE_DR;
        tick();
        jtag_state = TAP_IDLE;
    endtask

    task automatic dr_cmd(input logic [3:0] op, input logic [31:0] data);
        logic [31:0] junk;
        load_ir(op);
        dr_scan(data, junk);
        dr_update();
    endtask

    task automatic read_status(output logic [31:0] st);
        load_ir(OP_STATUS);
        dr_scan(32'h0, st);
        dr_update();
    endtask

    task automatic probe(input logic [31:0] pc);
        core_pc       = pc;
        core_pc_valid = 1'b1;
        tick();
        core_pc_valid = 1'b0;
    endtask

    // Holds the pending request for lat cycles, acking in the last one, and
    // checks the bus against the expected transfer throughout.
    task automatic mem_service(input int lat, input logic [31:0] rdata,
                               input logic [31:0] exp_addr, input logic exp_we,
                               input logic [31:0] exp_wdata, input string tag);
        int hi = 0;
        bit stable = 1'b1;
        for (int i = 0; i < lat; i++) begin
            if (mem_bus.mem_req === 1'b1) hi++;
            if (mem_bus.mem_addr !== exp_addr || mem_bus.mem_we !== exp_we ||
                (exp_we && mem_bus.mem_wdata !== exp_wdata)) stable = 1'b0;
            if (i == lat - 1) begin
                mem_bus.mem_ack   = 1'b1;
                mem_bus.mem_rdata = rdata;
            end
            tick();
        end
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 32'hBAD0_BAD0;
        check({tag, "_req_cycles"}, 64'(hi), 64'(lat));
        check({tag, "_bus_stable"}, 64'(stable), 64'd1);
        check({tag, "_req_drop"}, 64'(mem_bus.mem_req), 64'd0);
    endtask

    initial begin
        logic [31:0] st, v, d, rd, pc, addr_m, rpc_m;
        logic [31:0] bp_q[$];
        bit mask_m, halt_m, hit, in_q;
        int lat, n_set;

        reset             = 1'b1;
        jtag_state        = TAP_IDLE;
        tdi               = 1'b0;
        core_pc           = '0;
        core_pc_valid     = 1'b0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
        repeat (3) tick();

        check("rst_tdo", 64'(tdo), 64'd0);
        check("rst_req", 64'(mem_bus.mem_req), 64'd0);
        check("rst_we", 64'(mem_bus.mem_we), 64'd0);
        check("rst_addr", 64'(mem_bus.mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_bus.mem_wdata), 64'd0);
        check("rst_halt", 64'(halt), 64'd0);
        check("rst_step", 64'(step), 64'd0);
        reset = 1'b0;
        tick();
        read_status(st);
        check("rst_status", 64'(st), 64'd0);
        load_ir(OP_READ_MEM);
        dr_scan(32'h0, v);
        check("rst_rdata", 64'(v), 64'd0);

        // Write with 3-cycle ack latency
        dr_cmd(OP_SET_ADDR, 32'h1000);
        check("wr_set_addr", 64'(mem_bus.mem_addr), 64'h1000);
        dr_cmd(OP_WRITE_MEM, 32'hDEADBEEF);
        mem_service(3, 32'h0, 32'h1000, 1'b1, 32'hDEADBEEF, "wr");
        check("wr_addr_inc", 64'(mem_bus.mem_addr), 64'h1004);

        // Read then capture/shift out LSB first
        dr_cmd(OP_SET_ADDR, 32'h2000);
        dr_cmd(OP_READ_MEM, 32'h0);
        mem_service(2, 32'h12345678, 32'h2000, 1'b0, 32'h0, "rd");
        dr_scan(32'h0, v);
        check("rd_tdo_seq", 64'(v), 64'h12345678);
        check("rd_addr_inc", 64'(mem_bus.mem_addr), 64'h2004);

        // Address wrap
        dr_cmd(OP_SET_ADDR, 32'hFFFF_FFFC);
        dr_cmd(OP_WRITE_MEM, 32'h0BAD_F00D);
        mem_service(1, 32'h0, 32'hFFFF_FFFC, 1'b1, 32'h0BAD_F00D, "wrap");
        check("wrap_addr", 64'(mem_bus.mem_addr), 64'h0);

        // New access accepted in the ack cycle
        dr_cmd(OP_SET_ADDR, 32'h3000);
        dr_cmd(OP_WRITE_MEM, 32'h1111_1111);
        dr_scan(32'h2222_2222, v);
        jtag_state      = TAP_UPDATE_DR;
        mem_bus.mem_ack = 1'b1;
        tick();
        mem_bus.mem_ack = 1'b0;
        jtag_state      = TAP_IDLE;
        check("ackcyc_req", 64'(mem_bus.mem_req), 64'd1);
        mem_service(1, 32'h0, 32'h3004, 1'b1, 32'h2222_2222, "ackcyc");
        check("ackcyc_addr", 64'(mem_bus.mem_addr), 64'h3008);
        read_status(st);
        check("ackcyc_status", 64'(st), 64'h0);

        // Breakpoint halt, resume masking
        dr_cmd(OP_SET_BP, 32'h80);
        core_pc = 32'h80;
        check("bp_pre_halt", 64'(halt), 64'd0);
        core_pc_valid = 1'b1;
        tick();
        check("bp_halt", 64'(halt), 64'd1);
        read_status(st);
        check("bp_status", 64'(st), 64'h19);
        load_ir(OP_RESUME);
        dr_update();
        check("bp_resume_halt", 64'(halt), 64'd0);
        repeat (3) tick();
        check("bp_masked_halt", 64'(halt), 64'd0);
        read_status(st);
        check("bp_resume_status", 64'(st), 64'h10);
        core_pc = 32'h84;
        tick();
        check("bp_other_pc", 64'(halt), 64'd0);
        core_pc = 32'h80;
        tick();
        check("bp_rehit", 64'(halt), 64'd1);
        core_pc_valid = 1'b0;
        load_ir(OP_RESUME);
        dr_update();
        dr_cmd(OP_CLR_BP, 32'h0);

        // HALT, STEP, then STEP while running
        load_ir(OP_HALT);
        dr_update();
        check("halt_cmd", 64'(halt), 64'd1);
        load_ir(OP_STEP);
        dr_update();
        check("step_pulse", 64'(step), 64'd1);
        check("step_halt_hi", 64'(halt), 64'd1);
        tick();
        check("step_end", 64'(step), 64'd0);
        check("step_halt_hold", 64'(halt), 64'd1);
        load_ir(OP_RESUME);
        dr_update();
        check("run_halt", 64'(halt), 64'd0);
        load_ir(OP_STEP);
        dr_update();
        check("run_step", 64'(step), 64'd0);
        tick();
        check("run_step2", 64'(step), 64'd0);

        // Access while busy is dropped and sets err
        dr_cmd(OP_SET_ADDR, 32'h4000);
        dr_cmd(OP_WRITE_MEM, 32'hA5A5A5A5);
        dr_cmd(OP_WRITE_MEM, 32'h5A5A5A5A);
        check("busy_wdata", 64'(mem_bus.mem_wdata), 64'hA5A5A5A5);
        read_status(st);
        check("busy_status", 64'(st), 64'h6);
        mem_service(1, 32'h0, 32'h4000, 1'b1, 32'hA5A5A5A5, "busy");
        repeat (2) tick();
        check("busy_no_replay", 64'(mem_bus.mem_req), 64'd0);
        read_status(st);
        check("err_cleared", 64'(st), 64'h0);

        // Slot wrap overwrites the oldest breakpoint
        for (int i = 1; i <= 5; i++) dr_cmd(OP_SET_BP, 32'(i * 32'h100));
        read_status(st);
        check("wrap_bp_ptr", 64'(st), 64'h10);
        probe(32'h100);
        check("wrap_A_gone", 64'(halt), 64'd0);
        probe(32'h500);
        check("wrap_E_hit", 64'(halt), 64'd1);
        load_ir(OP_RESUME);
        dr_update();
        probe(32'h200);
        check("wrap_B_hit", 64'(halt), 64'd1);
        load_ir(OP_RESUME);
        dr_update();
        dr_cmd(OP_CLR_BP, 32'h0);
        probe(32'h300);
        check("clr_no_hit", 64'(halt), 64'd0);

        // Reset in the middle of a request
        dr_cmd(OP_WRITE_MEM, 32'hCAFEF00D);
        check("mid_req", 64'(mem_bus.mem_req), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_req", 64'(mem_bus.mem_req), 64'd0);
        check("mid_rst_addr", 64'(mem_bus.mem_addr), 64'd0);
        tick();
        reset           = 1'b0;
        mem_bus.mem_ack = 1'b1;
        tick();
        mem_bus.mem_ack = 1'b0;
        check("late_ack_req", 64'(mem_bus.mem_req), 64'd0);
        check("late_ack_addr", 64'(mem_bus.mem_addr), 64'd0);

        // Randomized phase against a behavioural model
        addr_m = '0;
        mask_m = 1'b0;
        halt_m = 1'b0;
        rpc_m  = '0;
        n_set  = 0;
        bp_q.delete();
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 4))
                0: begin
                    v = $urandom & 32'hFFFF_FFFC;
                    dr_cmd(OP_SET_ADDR, v);
                    addr_m = v;
                    check("rnd_set_addr", 64'(mem_bus.mem_addr), 64'(addr_m));
                end
                1: begin
                    d   = $urandom;
                    lat = $urandom_range(1, 4);
                    dr_cmd(OP_WRITE_MEM, d);
                    mem_service(lat, $urandom, addr_m, 1'b1, d, "rnd_wr");
                    addr_m = addr_m + 32'd4;
                    check("rnd_wr_addr", 64'(mem_bus.mem_addr), 64'(addr_m));
                end
                2: begin
                    rd  = $urandom;
                    lat = $urandom_range(1, 4);
                    dr_cmd(OP_READ_MEM, $urandom);
                    mem_service(lat, rd, addr_m, 1'b0, 32'h0, "rnd_rd");
                    addr_m = addr_m + 32'd4;
                    dr_scan(32'h0, v);
                    check("rnd_rd_data", 64'(v), 64'(rd));
                    check("rnd_rd_addr", 64'(mem_bus.mem_addr), 64'(addr_m));
                end
                3: begin
                    v = 32'($urandom_range(0, 63)) << 2;
                    dr_cmd(OP_SET_BP, v);
                    bp_q.push_back(v);
                    if (bp_q.size() > NUM_BP) void'(bp_q.pop_front());
                    n_set++;
                end
                default: begin
                    if (bp_q.size() > 0 && $urandom_range(0, 1) == 1)
                        pc = bp_q[$urandom_range(0, bp_q.size() - 1)];
                    else
                        pc = 32'($urandom_range(0, 63)) << 2;
                    in_q = 1'b0;
                    foreach (bp_q[k]) if (bp_q[k] == pc) in_q = 1'b1;
                    hit = in_q && !(mask_m && pc == rpc_m);
                    if (mask_m && pc != rpc_m) mask_m = 1'b0;
                    if (hit) halt_m = 1'b1;
                    probe(pc);
                    check("rnd_probe_halt", 64'(halt), 64'(halt_m));
                    if (halt_m) begin
                        load_ir(OP_RESUME);
                        dr_update();
                        halt_m = 1'b0;
                        mask_m = 1'b1;
                        rpc_m  = pc;
                        check("rnd_resume", 64'(halt), 64'd0);
                    end
                end
            endcase
        end
        read_status(st);
        check("rnd_status", 64'(st), 64'((n_set % NUM_BP) << 4));
        check("rnd_final_addr", 64'(mem_bus.mem_addr), 64'(addr_m));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
